// File: rtl/lif_pkg.sv
// Shared defaults and helpers for the leaky integrate-and-fire neuron.
// Optional feature macro: LIF_REFRACTORY_EN (see lif_core).
package lif_pkg;

  localparam int LIF_WIDTH      = 8;
  localparam int LIF_THRESHOLD  = 200;
  localparam int LIF_LEAK_SHIFT = 1;
  localparam int LIF_REFRACT    = 2;

  // Saturate a signed membrane update into the unsigned potential range.
  function automatic logic [LIF_WIDTH-1:0] lif_clamp(input logic signed [LIF_WIDTH+1:0] diff);
    logic signed [LIF_WIDTH+1:0] max_v;
    max_v = $signed({2'b00, {LIF_WIDTH{1'b1}}});
    if (diff < 0) begin
      lif_clamp = '0;
    end else if (diff > max_v) begin
      lif_clamp = '1;
    end else begin
      lif_clamp = diff[LIF_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_core.sv
// LIF neuron arithmetic: leak, integrate, threshold, subtract, saturate.
// LIF_REFRACTORY_EN adds a post-spike window that blocks input and firing.
module lif_core
  import lif_pkg::*;
#(
  parameter int THRESHOLD  = LIF_THRESHOLD,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
  parameter int REFRACT    = LIF_REFRACT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LIF_WIDTH-1:0] cur_i,
  output logic [LIF_WIDTH-1:0] state_o,
  output logic                 spike_o
);

  localparam logic [LIF_WIDTH-1:0] THRESH_V = LIF_WIDTH'(THRESHOLD);

  logic [LIF_WIDTH-1:0]        state_q, state_d;
  logic                        spike_q;
  logic                        fire;
  logic [LIF_WIDTH-1:0]        cur_eff;
  logic [LIF_WIDTH:0]          sum;
  logic signed [LIF_WIDTH+1:0] diff;

`ifdef LIF_REFRACTORY_EN
  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  logic [RW-1:0] refr_q, refr_d;
  logic          refr_active;

  assign refr_active = (refr_q != '0);
  assign fire        = (state_q >= THRESH_V) && !refr_active;
  assign cur_eff     = refr_active ? '0 : cur_i;

  always_comb begin
    refr_d = refr_q;
    if (fire) begin
      refr_d = RW'(REFRACT);
    end else if (refr_active) begin
      refr_d = refr_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refr_q <= '0;
    end else begin
      refr_q <= refr_d;
    end
  end
`else
  assign fire    = (state_q >= THRESH_V);
  assign cur_eff = cur_i;
`endif

  // All terms come from the current state, so a firing cycle both leaks and subtracts.
  assign sum     = {1'b0, cur_eff} + {1'b0, (state_q >> LEAK_SHIFT)};
  assign diff    = $signed({1'b0, sum}) - $signed(fire ? {2'b00, THRESH_V} : {(LIF_WIDTH+2){1'b0}});
  assign state_d = lif_clamp(diff);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      spike_q <= fire;
    end
  end

  assign state_o = state_q;
  assign spike_o = spike_q;

endmodule

// File: rtl/tt_um_lif_zb_copy.sv
// TinyTapeout wrapper around a single LIF neuron; pin mapping only.
// Optional feature macro LIF_REFRACTORY_EN is handled inside lif_core.
module tt_um_lif_zb_copy
  import lif_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic spike;
  logic unused_ok;

  // rst_n is active-high on this wrapper despite its name.
  lif_core #(
    .THRESHOLD (LIF_THRESHOLD),
    .LEAK_SHIFT(LIF_LEAK_SHIFT),
    .REFRACT   (LIF_REFRACT)
  ) u_core (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .cur_i  (ui_in),
    .state_o(uo_out),
    .spike_o(spike)
  );

  assign uio_out   = {spike, 7'b0};
  assign uio_oe    = 8'hFF;
  assign unused_ok = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_lif_zb_copy.sv
// Directed-vector bench for the LIF neuron wrapper (default build).
module tb_tt_um_lif_zb_copy;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic       rst;
    logic [7:0] ui;
    logic [7:0] uo;
    logic [7:0] uio;
  } vec_t;

  vec_t vecs[$];

  tt_um_lif_zb_copy dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input int ui, input int uo, input int uio);
    vec_t v;
    v.rst = r;
    v.ui  = 8'(ui);
    v.uo  = 8'(uo);
    v.uio = 8'(uio);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", name, act, act, exp, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [7:0] ui);
    @(negedge clk);
    rst_n = r;
    ui_in = ui;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    ena     = 1'b1;
    ui_in   = 8'd0;
    uio_in  = 8'hA5;

    // Reset for two edges.
    add(1, 0, 0, 0);
    add(1, 0, 0, 0);
    // ui=120 from reset: fires on 210, spike accompanies 25.
    add(0, 120, 120, 0);
    add(0, 120, 180, 0);
    add(0, 120, 210, 0);
    add(0, 120, 25, 8'h80);
    add(0, 120, 132, 0);
    add(0, 120, 186, 0);
    add(0, 120, 213, 0);
    add(0, 120, 26, 8'h80);
    // ui=100 settles at 199 and never fires.
    add(1, 100, 0, 0);
    add(0, 100, 100, 0);
    add(0, 100, 150, 0);
    add(0, 100, 175, 0);
    add(0, 100, 187, 0);
    add(0, 100, 193, 0);
    add(0, 100, 196, 0);
    add(0, 100, 198, 0);
    add(0, 100, 199, 0);
    add(0, 100, 199, 0);
    add(0, 100, 199, 0);
    // Pure leak from 199 decays to 0 without underflow.
    add(0, 0, 99, 0);
    add(0, 0, 49, 0);
    add(0, 0, 24, 0);
    add(0, 0, 12, 0);
    add(0, 0, 6, 0);
    add(0, 0, 3, 0);
    add(0, 0, 1, 0);
    add(0, 0, 0, 0);
    add(0, 0, 0, 0);
    // Firing from 210 with no input: 105-200 floors at 0.
    add(1, 120, 0, 0);
    add(0, 120, 120, 0);
    add(0, 120, 180, 0);
    add(0, 120, 210, 0);
    add(0, 0, 0, 8'h80);
    add(0, 0, 0, 0);
    // ui=255: saturation at 255 alternating with spikes.
    add(1, 255, 0, 0);
    add(0, 255, 255, 0);
    add(0, 255, 182, 8'h80);
    add(0, 255, 255, 0);
    add(0, 255, 182, 8'h80);
    add(0, 255, 255, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ui);
      check($sformatf("vec%0d_uo_out", i), uo_out, vecs[i].uo);
      check($sformatf("vec%0d_uio_out", i), uio_out, vecs[i].uio);
      check($sformatf("vec%0d_uio_oe", i), uio_oe, 8'hFF);
    end

    // Reset asserted mid-run at state 180, then an identical restart.
    step(1, 8'd0);
    step(0, 8'd120);
    step(0, 8'd120);
    check("mid_pre_state", uo_out, 8'd180);
    step(1, 8'd120);
    check("mid_rst_uo", uo_out, 8'd0);
    check("mid_rst_spike", uio_out, 8'h00);
    step(0, 8'd120);
    check("restart_1", uo_out, 8'd120);
    step(0, 8'd120);
    check("restart_2", uo_out, 8'd180);
    step(0, 8'd120);
    check("restart_3", uo_out, 8'd210);
    step(0, 8'd120);
    check("restart_4", uo_out, 8'd25);
    check("restart_4_spike", uio_out, 8'h80);
    step(0, 8'd120);
    check("restart_5_spike", uio_out, 8'h00);

    // Reset while a spike is pending clears the spike on the same edge.
    step(0, 8'd120);
    step(0, 8'd120);
    step(0, 8'd120);
    step(1, 8'd120);
    check("rst_over_fire_uo", uo_out, 8'd0);
    check("rst_over_fire_spike", uio_out, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
